// File: rtl/traffic_timer_if.sv
// traffic_timer_if: links the traffic-light FSM to its countdown timer.
//   master (FSM side / bench): drives the program strobe, select and value,
//                              the interval code and start_timer;
//                              receives expired, remaining and busy.
//   slave  (timer side):       the reverse of master.
interface traffic_timer_if;
    logic       Prog_Sync;
    logic [1:0] Time_Param_Sel;
    logic [3:0] Time_Value;
    logic [1:0] interval;
    logic       start_timer;
    logic       expired;
    logic [3:0] remaining;
    logic       busy;

    modport master (
        output Prog_Sync, Time_Param_Sel, Time_Value, interval, start_timer,
        input  expired, remaining, busy
    );

    modport slave (
        input  Prog_Sync, Time_Param_Sel, Time_Value, interval, start_timer,
        output expired, remaining, busy
    );
endinterface

// File: rtl/traffic_timer.sv
// traffic_timer: programmable one-second countdown timer for the traffic FSM.
//   clk        system clock, rising edge
//   Reset_Sync synchronous active-high reset
//   bus        traffic_timer_if.slave
//                in : Prog_Sync, Time_Param_Sel, Time_Value, interval, start_timer
//                out: expired (registered 1-cycle pulse), remaining, busy
// It holds the base, extended and yellow durations. A prescaler makes one-second
// ticks while a count is running.
module traffic_timer #(
    parameter int TICKS_PER_SEC = 1000000,
    parameter int DEF_BASE      = 6,
    parameter int DEF_EXT       = 3,
    parameter int DEF_YEL       = 2
) (
    input  logic           clk,
    input  logic           Reset_Sync,
    traffic_timer_if.slave bus
);
    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0] DEF_BASE_V = 4'(DEF_BASE);
    localparam logic [3:0] DEF_EXT_V  = 4'(DEF_EXT);
    localparam logic [3:0] DEF_YEL_V  = 4'(DEF_YEL);

    logic [3:0]    base_q, base_d;
    logic [3:0]    ext_q,  ext_d;
    logic [3:0]    yel_q,  yel_d;
    logic [3:0]    rem_q,  rem_d;
    logic [PW-1:0] pre_q,  pre_d;
    logic          expired_q, expired_d;
    logic          tick;

    always_comb begin
        base_d    = base_q;
        ext_d     = ext_q;
        yel_d     = yel_q;
        rem_d     = rem_q;
        pre_d     = pre_q;
        expired_d = 1'b0;
        tick      = (rem_q != 4'd0) && (pre_q == PRE_MAX);

        // A value of zero restores the register's default.
        if (bus.Prog_Sync) begin
            case (bus.Time_Param_Sel)
                2'b00:   base_d = (bus.Time_Value == 4'd0) ? DEF_BASE_V : bus.Time_Value;
                2'b01:   ext_d  = (bus.Time_Value == 4'd0) ? DEF_EXT_V  : bus.Time_Value;
                2'b10:   yel_d  = (bus.Time_Value == 4'd0) ? DEF_YEL_V  : bus.Time_Value;
                default: ;
            endcase
        end

        // The start loads from the _q registers. A write on the same edge
        // therefore only takes effect on the next count. A start also drops
        // any tick on the same edge, and the aborted count issues no expired pulse.
        if (bus.start_timer) begin
            case (bus.interval)
                2'b01:   rem_d = ext_q;
                2'b10:   rem_d = yel_q;
                default: rem_d = base_q;
            endcase
            pre_d = '0;
        end else if (rem_q != 4'd0) begin
            if (tick) begin
                pre_d     = '0;
                rem_d     = rem_q - 4'd1;
                expired_d = (rem_q == 4'd1);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            base_q    <= DEF_BASE_V;
            ext_q     <= DEF_EXT_V;
            yel_q     <= DEF_YEL_V;
            rem_q     <= 4'd0;
            pre_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            base_q    <= base_d;
            ext_q     <= ext_d;
            yel_q     <= yel_d;
            rem_q     <= rem_d;
            pre_q     <= pre_d;
            expired_q <= expired_d;
        end
    end

    assign bus.expired   = expired_q;
    assign bus.remaining = rem_q;
    assign bus.busy      = (rem_q != 4'd0);
endmodule

// File: tb/tb_traffic_timer.sv
module tb_traffic_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    traffic_timer_if tif ();

    traffic_timer #(.TICKS_PER_SEC(4)) dut (
        .clk        (clk),
        .Reset_Sync (rst),
        .bus        (tif)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle. Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] iv);
        tif.interval    = iv;
        tif.start_timer = 1'b1;
        step();
        tif.start_timer = 1'b0;
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        tif.Prog_Sync      = 1'b1;
        tif.Time_Param_Sel = sel;
        tif.Time_Value     = val;
        step();
        tif.Prog_Sync      = 1'b0;
    endtask

    // Called just after a start edge. Counts edges until expired rises,
    // within a bound. Then checks that the pulse lasts one cycle and the
    // timer is idle.
    task automatic wait_exp(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (tif.expired !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, exp_edges);
        check({tag, "_rem_at_exp"}, tif.remaining, 0);
        step();
        check({tag, "_pulse_1cyc"}, tif.expired, 0);
        check({tag, "_idle_busy"}, tif.busy, 0);
    endtask

    initial begin
        int pulses;
        tif.Prog_Sync      = 1'b0;
        tif.Time_Param_Sel = 2'b00;
        tif.Time_Value     = 4'd0;
        tif.interval       = 2'b00;
        tif.start_timer    = 1'b0;

        // reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_expired", tif.expired, 0);
        check("rst_remaining", tif.remaining, 0);
        check("rst_busy", tif.busy, 0);
        step();
        check("idle_expired", tif.expired, 0);
        check("idle_remaining", tif.remaining, 0);

        // default base count: 6 s * 4 ticks
        start(2'b00);
        check("base_load", tif.remaining, 6);
        check("base_busy", tif.busy, 1);
        wait_exp("base", 24);

        // program ext=5, yel=0 (restore to 2), sel=11 no-op
        prog(2'b01, 4'd5);
        start(2'b01);
        check("ext5_load", tif.remaining, 5);
        wait_exp("ext5", 20);
        prog(2'b10, 4'd0);
        start(2'b10);
        check("yel_restore_load", tif.remaining, 2);
        wait_exp("yel_restore", 8);
        prog(2'b11, 4'd9);
        start(2'b00);
        check("sel11_base", tif.remaining, 6);
        wait_exp("sel11_base", 24);
        start(2'b01);
        check("sel11_ext", tif.remaining, 5);
        wait_exp("sel11_ext", 20);
        start(2'b10);
        check("sel11_yel", tif.remaining, 2);
        wait_exp("sel11_yel", 8);

        // restart at edge 10 with yellow
        start(2'b00);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (tif.expired === 1'b1) pulses++;
        end
        check("restart_rem_before", tif.remaining, 4);
        start(2'b10);
        check("restart_load", tif.remaining, 2);
        check("restart_no_early_pulse", pulses, 0);
        wait_exp("restart", 8);

        // reset at edge 12 of a base count; ext (5) reverts to default 3
        start(2'b00);
        for (int i = 0; i < 11; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_rem", tif.remaining, 0);
        check("midrst_busy", tif.busy, 0);
        pulses = (tif.expired === 1'b1) ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tif.expired === 1'b1) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        start(2'b01);
        check("midrst_ext_default", tif.remaining, 3);
        wait_exp("midrst_ext", 12);

        // write base=9 on the same edge as a base start
        tif.Prog_Sync      = 1'b1;
        tif.Time_Param_Sel = 2'b00;
        tif.Time_Value     = 4'd9;
        tif.interval       = 2'b00;
        tif.start_timer    = 1'b1;
        step();
        tif.Prog_Sync      = 1'b0;
        tif.start_timer    = 1'b0;
        check("simul_old_value", tif.remaining, 6);
        wait_exp("simul_old", 24);
        start(2'b00);
        check("simul_new_value", tif.remaining, 9);
        wait_exp("simul_new", 36);
        prog(2'b00, 4'd0);

        // start on the tick edge: reload without decrement
        start(2'b00);
        for (int i = 0; i < 3; i++) step();
        check("tick_pre_rem", tif.remaining, 6);
        start(2'b00);
        check("tick_start_reload", tif.remaining, 6);
        wait_exp("tick_start", 24);

        // interval 11 behaves as base
        start(2'b11);
        check("iv11_load", tif.remaining, 6);
        wait_exp("iv11", 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Programmable countdown timer that sits directly downstream of the traffic-light FSM.
- Consumes the FSM's interval code and start_timer pulse, and returns the expired pulse the FSM advances on.
- Holds the three run-time-programmable light durations (base, extended, yellow) and a clock prescaler that generates one-second ticks.
- Exposes remaining seconds for a display.

Parameters:
- TICKS_PER_SEC, 1000000: clk cycles per one-second tick (bench overrides to 4). Must be >= 2.
- DEF_BASE, 6: reset and restore value of the base interval, in seconds.
- DEF_EXT, 3: reset and restore value of the extended interval, in seconds.
- DEF_YEL, 2: reset and restore value of the yellow interval, in seconds.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- Reset_Sync  in  1  synchronous active-high reset.
- Prog_Sync  in  1  synchronised program strobe; writes Time_Value into the register chosen by Time_Param_Sel.
- Time_Param_Sel  in  2  register select: 00 base, 01 extended, 10 yellow, 11 none.
- Time_Value  in  4  seconds value to program (0 means restore the default).
- interval  in  2  from FSM: 00 base, 01 extended, 10 yellow, 11 treated as base.
- start_timer  in  1  from FSM: load and restart the countdown.
- expired  out  1  to FSM: one-cycle pulse when the countdown completes.
- remaining  out  4  seconds left in the current countdown; 0 when idle.
- busy  out  1  high while remaining != 0.

Behaviour:
- Reset: if Reset_Sync is high at an edge, then after that edge:
  - base/ext/yel registers = DEF_BASE/DEF_EXT/DEF_YEL;
  - remaining = 0, prescaler = 0, expired = 0, busy = 0.
  - Reset overrides all other inputs, including a reset asserted mid-count: the count aborts and no expired pulse is issued.
- Parameter write: on an edge with Prog_Sync = 1 and Time_Param_Sel != 11, the selected register takes Time_Value, or its default if Time_Value = 0.
  - Sel = 11: no register changes.
  - A write never alters a countdown already in progress.
- Start: on an edge with start_timer = 1:
  - remaining loads the register selected by interval, using the value held before any same-edge Prog_Sync write;
  - prescaler clears to 0.
  - Start while counting restarts the count; no expired pulse is issued for the aborted count.
- Prescaler: runs only while remaining != 0.
  - Increments each cycle and wraps from TICKS_PER_SEC-1 to 0.
  - tick = (prescaler == TICKS_PER_SEC-1).
- Countdown: on an edge with tick = 1 and start_timer = 0:
  - remaining decrements by 1;
  - if remaining was 1, it becomes 0 and expired is registered high for exactly one cycle.
- Start and tick on the same edge: the start wins and the tick is dropped.
- Latency: expired is high in the cycle beginning N*TICKS_PER_SEC edges after the start edge, where N is the loaded value.
- Idle: with remaining = 0 and no start, expired stays 0 and the prescaler holds at 0.
- Outputs remaining and busy are combinational from registers; expired is a registered output.
- No arithmetic wraps: remaining never decrements below 0; a loaded value lies in 1..15.

Test Plan:
- Initial load and reset: TICKS_PER_SEC=4; hold Reset_Sync for 1 cycle -> expired=0, remaining=0, busy=0. Then start_timer with interval=00 -> remaining=6, expired pulses for 1 cycle exactly 24 edges after the start edge, remaining=0 afterwards.
- Programming: Prog_Sync with Sel=01, Value=5; then start with interval=01 -> expired after 20 edges. Prog_Sync with Sel=10, Value=0; start with interval=10 -> register restored to 2, expired after 8 edges. Prog_Sync with Sel=11, Value=9 -> base/ext/yel unchanged.
- Restart mid-count: start with interval=00, then start again at edge 10 with interval=10 -> exactly one expired pulse, 8 edges after the second start.
- Reset mid-count: start with interval=00, assert Reset_Sync at edge 12 -> no expired pulse; remaining=0; a previously programmed ext value of 5 reads back as 3 on the next interval=01 count (12 edges).
- Simultaneous events:
  - Prog_Sync (Sel=00, Value=9) on the same edge as start with interval=00 -> this count loads 6; the next count loads 9.
  - Start on the tick edge of a running count -> count reloads with no decrement.
- Interval code 11: start with interval=11 -> behaves as base (24 edges at default).
